// File: rtl/control_clave_if.sv
// Keypad-side bundle for control_clave: key lines, enter and status outputs.
// cambio_clave exists only when CAMBIO_CLAVE_EN is defined.
interface control_clave_if;
  logic [9:0] teclas;
  logic       enter;
`ifdef CAMBIO_CLAVE_EN
  logic       cambio_clave;
`endif
  logic       verificacion;
  logic       error;
  logic       bloqueado;
  logic [3:0] digitos;

  modport master (
    output teclas, enter,
`ifdef CAMBIO_CLAVE_EN
    cambio_clave,
`endif
    input  verificacion, error, bloqueado, digitos
  );

  modport slave (
    input  teclas, enter,
`ifdef CAMBIO_CLAVE_EN
    cambio_clave,
`endif
    output verificacion, error, bloqueado, digitos
  );
endinterface

// File: rtl/control_clave.sv
// Keypad entry sequencer: captures BCD digits, checks the code, locks out after repeated failures.
// Define CAMBIO_CLAVE_EN to allow changing the stored key after a successful entry.
module control_clave #(
  parameter int unsigned                 N_DIGITOS      = 4,
  parameter logic [4*N_DIGITOS-1:0]      CLAVE_INICIAL  = 16'h1234,
  parameter int unsigned                 MAX_INTENTOS   = 3,
  parameter int unsigned                 BLOQUEO_CICLOS = 1000
) (
  input logic           clk,
  input logic           rst,
  control_clave_if.slave bus
);

  localparam int unsigned BufW    = 4 * N_DIGITOS;
  localparam int unsigned FallosW = $clog2(MAX_INTENTOS + 1);
  localparam int unsigned CntW    = (BLOQUEO_CICLOS > 1) ? $clog2(BLOQUEO_CICLOS) : 1;

  typedef enum logic [2:0] {
    StEspera,
    StCaptura,
    StCompara,
    StBloqueo
`ifdef CAMBIO_CLAVE_EN
    , StNueva
`endif
  } estado_e;

  estado_e            state_q, state_d;
  logic [9:0]         teclas_q;
  logic               enter_q;
  logic [BufW-1:0]    buf_q, buf_d;
  logic [3:0]         digitos_q, digitos_d;
  logic [FallosW-1:0] fallos_q, fallos_d, fallos_inc;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               verif_q, verif_d;
  logic               error_q, error_d;
  logic               bloq_q, bloq_d;
  logic [BufW-1:0]    clave;

`ifdef CAMBIO_CLAVE_EN
  logic [BufW-1:0]    clave_q, clave_d;
  assign clave = clave_q;
`else
  assign clave = CLAVE_INICIAL;
`endif

  logic       tecla_ev, enter_ev, lleno, coincide;
  logic [3:0] bcd;

  // Only a press from an idle keypad counts; multi-hot or rolled-over keys wait for release.
  assign tecla_ev   = (teclas_q == '0) && $onehot(bus.teclas);
  assign enter_ev   = bus.enter && !enter_q;
  assign lleno      = (digitos_q == 4'(N_DIGITOS));
  assign coincide   = lleno && (buf_q == clave);
  assign fallos_inc = fallos_q + FallosW'(1);

  always_comb begin
    bcd = '0;
    for (int i = 0; i < 10; i++) begin
      if (bus.teclas[i]) bcd = 4'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StEspera;
      teclas_q  <= '0;
      enter_q   <= 1'b0;
      buf_q     <= '0;
      digitos_q <= '0;
      fallos_q  <= '0;
      cnt_q     <= '0;
      verif_q   <= 1'b0;
      error_q   <= 1'b0;
      bloq_q    <= 1'b0;
`ifdef CAMBIO_CLAVE_EN
      clave_q   <= CLAVE_INICIAL;
`endif
    end else begin
      state_q   <= state_d;
      teclas_q  <= bus.teclas;
      enter_q   <= bus.enter;
      buf_q     <= buf_d;
      digitos_q <= digitos_d;
      fallos_q  <= fallos_d;
      cnt_q     <= cnt_d;
      verif_q   <= verif_d;
      error_q   <= error_d;
      bloq_q    <= bloq_d;
`ifdef CAMBIO_CLAVE_EN
      clave_q   <= clave_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    digitos_d = digitos_q;
    fallos_d  = fallos_q;
    cnt_d     = cnt_q;
`ifdef CAMBIO_CLAVE_EN
    clave_d   = clave_q;
`endif
    case (state_q)
      StEspera, StCaptura: begin
        if (enter_ev) begin
          state_d = StCompara;
        end else if (tecla_ev) begin
          state_d = StCaptura;
          if (!lleno) begin
            buf_d     = (buf_q << 4) | BufW'(bcd);
            digitos_d = digitos_q + 4'd1;
          end
        end
      end
      StCompara: begin
        buf_d     = '0;
        digitos_d = '0;
        if (coincide) begin
          fallos_d = '0;
          state_d  = StEspera;
`ifdef CAMBIO_CLAVE_EN
          if (bus.cambio_clave) state_d = StNueva;
`endif
        end else begin
          fallos_d = fallos_inc;
          if (32'(fallos_inc) >= MAX_INTENTOS) begin
            state_d = StBloqueo;
            cnt_d   = CntW'(BLOQUEO_CICLOS - 1);
          end else begin
            state_d = StEspera;
          end
        end
      end
      StBloqueo: begin
        if (cnt_q == '0) begin
          state_d  = StEspera;
          fallos_d = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
`ifdef CAMBIO_CLAVE_EN
      StNueva: begin
        if (enter_ev) begin
          if (lleno) clave_d = buf_q;
          buf_d     = '0;
          digitos_d = '0;
          state_d   = StEspera;
        end else if (tecla_ev && !lleno) begin
          buf_d     = (buf_q << 4) | BufW'(bcd);
          digitos_d = digitos_q + 4'd1;
        end
      end
`endif
      default: state_d = StEspera;
    endcase
  end

  always_comb begin
    verif_d = 1'b0;
    error_d = 1'b0;
    case (state_q)
      StCompara: begin
        verif_d = coincide;
        error_d = !coincide;
      end
`ifdef CAMBIO_CLAVE_EN
      StNueva: begin
        verif_d = enter_ev && lleno;
        error_d = enter_ev && !lleno;
      end
`endif
      default: ;
    endcase
    bloq_d = (state_d == StBloqueo);
  end

  assign bus.verificacion = verif_q;
  assign bus.error        = error_q;
  assign bus.bloqueado    = bloq_q;
  assign bus.digitos      = digitos_q;

endmodule

// File: tb/tb_control_clave.sv
// Bench for control_clave: code table plus lockout, held-key, reset and key-change sequences.
module tb_control_clave;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  control_clave_if bus ();

  control_clave dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit ok;
    int at;
  } pulso_t;
  pulso_t sb[$];

  typedef struct {
    logic [31:0] code;
    int          n;
    int          dig;
    bit          ok;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic press(input int d);
    bus.teclas = 10'(1 << d);
    tick();
    bus.teclas = '0;
    tick();
  endtask

  task automatic press_code(input logic [31:0] code, input int n);
    logic [31:0] c;
    for (int i = 0; i < n; i++) begin
      c = code >> (4 * (n - 1 - i));
      press(int'(c[3:0]));
    end
  endtask

  // Pulse from COMPARA shows two cycles after the enter edge.
  task automatic do_enter(input bit ok, input int lat);
    pulso_t p;
    p.ok = ok;
    p.at = cyc + lat;
    sb.push_back(p);
    bus.enter = 1'b1;
    tick();
    bus.enter = 1'b0;
    tick();
    tick();
    tick();
  endtask

  always @(negedge clk) begin
    if (rst && (bus.verificacion || bus.error)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'd0, bus.verificacion, bus.error}, 32'd0);
      end else begin
        pulso_t p;
        p = sb.pop_front();
        check("pulse_kind", {30'd0, bus.verificacion, bus.error}, p.ok ? 32'd2 : 32'd1);
        check("pulse_cycle", cyc, p.at);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vec[8];
    int   t0;
    bit   seen;
    vec[0] = '{32'h1234, 4, 4, 1'b1};
    vec[1] = '{32'h1235, 4, 4, 1'b0};
    vec[2] = '{32'h123, 3, 3, 1'b0};
    vec[3] = '{32'h1234, 4, 4, 1'b1};
    vec[4] = '{32'h12345, 5, 4, 1'b1};
    vec[5] = '{32'h4321, 4, 4, 1'b0};
    vec[6] = '{32'h0, 0, 0, 1'b0};
    vec[7] = '{32'h1234, 4, 4, 1'b1};

    bus.teclas = '0;
    bus.enter  = 1'b0;
`ifdef CAMBIO_CLAVE_EN
    bus.cambio_clave = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_outputs", {bus.verificacion, bus.error, bus.bloqueado, bus.digitos}, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      press_code(vec[i].code, vec[i].n);
      @(negedge clk);
      check($sformatf("vec%0d_digitos", i), bus.digitos, vec[i].dig);
      tick();
      do_enter(vec[i].ok, 2);
      @(negedge clk);
      check($sformatf("vec%0d_cleared", i), bus.digitos, 32'd0);
      check($sformatf("vec%0d_bloq", i), bus.bloqueado, 32'd0);
    end

    // Three consecutive failures start the lockout.
    press_code(32'h1235, 4);
    do_enter(1'b0, 2);
    @(negedge clk);
    check("bloq_after_1err", bus.bloqueado, 32'd0);
    tick();
    press_code(32'h9999, 4);
    do_enter(1'b0, 2);
    press_code(32'h9999, 4);
    begin
      pulso_t p;
      p.ok = 1'b0;
      p.at = cyc + 2;
      sb.push_back(p);
      bus.enter = 1'b1;
      tick();
      bus.enter = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge clk);
        if (bus.bloqueado) seen = 1'b1;
      end
      t0 = cyc;
      check("bloq_rise", seen, 32'd1);
      check("bloq_rise_cycle", t0, p.at);
    end
    tick();
    press_code(32'h1234, 4);
    bus.enter = 1'b1;
    tick();
    bus.enter = 1'b0;
    tick();
    @(negedge clk);
    check("lock_digitos", bus.digitos, 32'd0);
    check("lock_still", bus.bloqueado, 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 1200 && !seen; k++) begin
      @(negedge clk);
      if (!bus.bloqueado) seen = 1'b1;
    end
    check("bloq_fall", seen, 32'd1);
    check("bloq_length", cyc - t0, 32'd1000);
    tick();
    press_code(32'h1234, 4);
    do_enter(1'b1, 2);

    // Held key counts once; multi-hot is ignored.
    bus.teclas = 10'(1 << 7);
    repeat (20) tick();
    bus.teclas = '0;
    tick();
    @(negedge clk);
    check("hold_digitos", bus.digitos, 32'd1);
    tick();
    bus.teclas = 10'b0000000011;
    tick();
    bus.teclas = '0;
    tick();
    @(negedge clk);
    check("multihot_digitos", bus.digitos, 32'd1);
    tick();
    do_enter(1'b0, 2);

    // Key on the enter edge is dropped, so 123+4 fails.
    press_code(32'h123, 3);
    bus.teclas = 10'(1 << 4);
    do_enter(1'b0, 2);
    bus.teclas = '0;
    tick();
    @(negedge clk);
    check("same_edge_digitos", bus.digitos, 32'd0);
    tick();
    press_code(32'h1234, 4);
    do_enter(1'b1, 2);

    // Asynchronous reset mid-entry.
    press_code(32'h12, 2);
    @(negedge clk);
    check("pre_rst_digitos", bus.digitos, 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_outputs", {bus.verificacion, bus.error, bus.bloqueado, bus.digitos}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    press_code(32'h1234, 4);
    do_enter(1'b1, 2);

`ifdef CAMBIO_CLAVE_EN
    bus.cambio_clave = 1'b1;
    press_code(32'h1234, 4);
    do_enter(1'b1, 2);
    bus.cambio_clave = 1'b0;
    press_code(32'h5678, 4);
    do_enter(1'b1, 1);
    press_code(32'h1234, 4);
    do_enter(1'b0, 2);
    press_code(32'h5678, 4);
    do_enter(1'b1, 2);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    press_code(32'h1234, 4);
    do_enter(1'b1, 2);
`endif

    repeat (4) tick();
    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
